dda_move_engine: RTL and testbench
==================================

Name: dda_move_engine

Overview:
- Parametrised, multi-axis successor to the single-axis coordinated-step DDA.
- Buffers host-supplied moves in a DEPTH-entry FIFO with a valid/ready write port.
- Executes each move as a fixed number of divided clock ticks. On every tick, each axis adds a second-order increment to a signed substep accumulator and emits a one-cycle step pulse when the accumulator goes positive.
- Sits between the SPI word handler and the per-axis microstepper/driver blocks.

Parameters:
- AXES, 2, number of stepper axes (1..8)
- DEPTH, 4, move FIFO entries (power of two, >=2)
- ACC_W, 64, width of accumulator, increment and increment-increment (signed)
- DUR_W, 32, width of move duration (ticks)
- ROLLBACK, 2**(ACC_W-1)-1, value subtracted from the accumulator on each step

Ports:
- CLK  in  1  clock
- resetn  in  1  synchronous, active-low reset
- clk_div  in  8  tick divisor; a tick occurs every clk_div+1 CLK cycles
- halt  in  1  abort: flush FIFO and current move
- mv_valid  in  1  move write strobe
- mv_ready  out  1  FIFO can accept a move
- mv_dur  in  DUR_W  move length in ticks
- mv_dir  in  AXES  per-axis direction bits
- mv_inc  in  AXES*ACC_W  per-axis initial increment; axis i at [i*ACC_W +: ACC_W]
- mv_incinc  in  AXES*ACC_W  per-axis increment-increment, same packing
- step_o  out  AXES  one-CLK step pulses
- dir_o  out  AXES  direction of the executing move
- busy  out  1  state != IDLE
- move_done  out  1  one-CLK pulse when a move completes
- fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (resetn=0 at a CLK edge):
  - FIFO empty, fifo_count=0, mv_ready=1.
  - State IDLE, all accumulators 0.
  - step_o=0, dir_o=0, busy=0, move_done=0.
- Write port:
  - A move is accepted on an edge where mv_valid && mv_ready.
  - mv_ready = !full && !halt.
  - Simultaneous accept and pop: fifo_count unchanged.
  - A write while full is ignored, with no corruption.
- States:
  - IDLE: if FIFO non-empty and !halt -> LOAD.
  - LOAD (1 cycle):
    - Pop head; latch dur into a tick down-counter, inc/incinc per axis, and dir into dir_o.
    - Div counter <= clk_div (sampled once per move).
    - If dur==0: pulse move_done, then go to IDLE if FIFO now empty, else LOAD (next move).
    - Otherwise -> RUN.
  - RUN:
    - If div counter != 0: decrement it.
    - Else a tick occurs; per axis: s = acc + inc_r (ACC_W two's-complement wrap).
      - If s > 0 (signed): acc <= s - ROLLBACK and step_o[i]=1 on the next cycle.
      - Else: acc <= s.
    - Also on a tick: inc_r <= inc_r + incinc; div counter <= clk_div; down-counter decrements.
    - On the tick that brings the down-counter to 0: move_done pulses next cycle; -> LOAD if FIFO non-empty, else IDLE.
  - Back-to-back moves add no gap beyond the one LOAD cycle.
- Latency:
  - Move accepted at edge N: LOAD at N+1, RUN from N+2.
  - First tick at N+2+clk_div; its step pulse is visible at N+3+clk_div.
  - A move of duration D produces exactly D ticks.
- Accumulators persist across moves and across halt. Only reset clears them.
- halt (level, checked every cycle, highest priority):
  - Flush FIFO (count 0) and go to IDLE.
  - Clear inc_r; step_o=0 next cycle.
  - No move_done pulse for an aborted move. dir_o holds.
  - Writes presented during halt are not accepted.
- A reset asserted mid-move discards everything and produces no pulses.

Optional Feature:
- Macro: DDA_POSITION_EN.
- When defined:
  - Adds output position_o (AXES*32, signed, axis i at [i*32 +: 32]).
  - On each step pulse, position_o[i] increments if dir_o[i]=1, else decrements.
  - Reset to 0 by resetn only; preserved across halt; wraps at 32 bits.
- When undefined: the port and its counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle: after resetn released -> mv_ready=1, fifo_count=0, busy=0, no step_o for 100 cycles.
- AXES=2, ACC_W=32, clk_div=0; one move dur=4, inc0=0x7FFFFFFF, inc1=0, incinc=0, dir=2'b01 -> exactly 4 step_o[0] pulses on consecutive cycles starting 3 cycles after accept; 0 step_o[1] pulses; dir_o=01; one move_done pulse.
- clk_div=3, same move -> step_o[0] pulses spaced 4 cycles apart; first at accept+6.
- Fill DEPTH=4 moves while the first runs -> mv_ready low at 4 queued; a write while full is dropped. Moves execute in order with a 1-cycle LOAD gap and 4 move_done pulses.
- dur=0 move followed by a dur=2 move -> move_done pulses twice, no steps from the first move.
- halt asserted mid-move with 2 queued -> fifo_count=0 next cycle, IDLE, no further steps or move_done. With DDA_POSITION_EN, position_o retains the step count taken so far (e.g. +2).

Source files
------------

// File: rtl/dda_move_engine.sv
// dda_move_engine: multi-axis second-order DDA step generator with a move FIFO.
//
// Moves (duration, per-axis direction, increment, increment-increment) are
// written through a valid/ready port into a DEPTH-entry FIFO. Each move is
// executed as mv_dur divided ticks. On every tick each axis adds its increment
// to a signed accumulator. When the sum goes positive, the axis emits a
// one-cycle step pulse and ROLLBACK is subtracted from the accumulator.
//
// Ports:
//   CLK, resetn     clock, synchronous active-low reset
//   clk_div         tick divisor (tick every clk_div+1 cycles, sampled per move)
//   halt            level abort: flushes FIFO and current move
//   mv_valid/ready  move write handshake
//   mv_dur          move length in ticks
//   mv_dir          per-axis direction
//   mv_inc          per-axis initial increment, axis i at [i*ACC_W +: ACC_W]
//   mv_incinc       per-axis increment-increment, same packing
//   step_o          one-cycle step pulses
//   dir_o           direction of the executing move
//   busy            engine not idle
//   move_done       one-cycle pulse on move completion
//   fifo_count      occupied FIFO entries
//   position_o      (only with DDA_POSITION_EN) per-axis signed 32-bit step count
//
// Optional feature macro: DDA_POSITION_EN
module dda_move_engine #(
  parameter int unsigned      AXES     = 2,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      ACC_W    = 64,
  parameter int unsigned      DUR_W    = 32,
  parameter logic [ACC_W-1:0] ROLLBACK = {1'b0, {(ACC_W-1){1'b1}}}
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic [7:0]                clk_div,
  input  logic                      halt,
  input  logic                      mv_valid,
  output logic                      mv_ready,
  input  logic [DUR_W-1:0]          mv_dur,
  input  logic [AXES-1:0]           mv_dir,
  input  logic [AXES*ACC_W-1:0]     mv_inc,
  input  logic [AXES*ACC_W-1:0]     mv_incinc,
  output logic [AXES-1:0]           step_o,
  output logic [AXES-1:0]           dir_o,
  output logic                      busy,
  output logic                      move_done,
`ifdef DDA_POSITION_EN
  output logic [AXES*32-1:0]        position_o,
`endif
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state;

  // Move FIFO
  logic [DUR_W-1:0]      dur_mem    [DEPTH];
  logic [AXES-1:0]       dir_mem    [DEPTH];
  logic [AXES*ACC_W-1:0] inc_mem    [DEPTH];
  logic [AXES*ACC_W-1:0] incinc_mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, push, pop;

  assign full       = (count == CW'(DEPTH));
  assign mv_ready   = !full && !halt;
  assign push       = mv_valid && mv_ready;
  assign pop        = (state == LOAD) && !halt;
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (push) begin
      dur_mem[wr_ptr]    <= mv_dur;
      dir_mem[wr_ptr]    <= mv_dir;
      inc_mem[wr_ptr]    <= mv_inc;
      incinc_mem[wr_ptr] <= mv_incinc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (halt) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Per-axis DDA datapath
  logic signed [ACC_W-1:0] acc      [AXES];
  logic signed [ACC_W-1:0] inc_r    [AXES];
  logic signed [ACC_W-1:0] incinc_r [AXES];
  logic signed [ACC_W-1:0] sum      [AXES];
  logic [DUR_W-1:0]        ticks_left;
  logic [7:0]              div_cnt;
  logic                    tick;
  logic [AXES-1:0]         step_next;

  assign tick = (state == RUN) && (div_cnt == '0) && !halt;

  always_comb begin
    step_next = '0;
    for (int unsigned i = 0; i < AXES; i++) begin
      sum[i] = acc[i] + inc_r[i];
      if (tick && (sum[i] > 0)) step_next[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state      <= IDLE;
      step_o     <= '0;
      dir_o      <= '0;
      move_done  <= 1'b0;
      ticks_left <= '0;
      div_cnt    <= '0;
      for (int unsigned i = 0; i < AXES; i++) begin
        acc[i]      <= '0;
        inc_r[i]    <= '0;
        incinc_r[i] <= '0;
      end
    end else begin
      step_o    <= step_next;
      move_done <= 1'b0;
      if (halt) begin
        state <= IDLE;
        for (int unsigned i = 0; i < AXES; i++) inc_r[i] <= '0;
      end else begin
        case (state)
          IDLE: if (count != '0) state <= LOAD;
          LOAD: begin
            ticks_left <= dur_mem[rd_ptr];
            dir_o      <= dir_mem[rd_ptr];
            div_cnt    <= clk_div;
            for (int unsigned i = 0; i < AXES; i++) begin
              inc_r[i]    <= inc_mem[rd_ptr][i*ACC_W +: ACC_W];
              incinc_r[i] <= incinc_mem[rd_ptr][i*ACC_W +: ACC_W];
            end
            if (dur_mem[rd_ptr] == '0) begin
              move_done <= 1'b1;
              // A same-cycle write is readable on the next LOAD cycle.
              state     <= ((count > CW'(1)) || push) ? LOAD : IDLE;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else begin
              div_cnt    <= clk_div;
              ticks_left <= ticks_left - 1'b1;
              for (int unsigned i = 0; i < AXES; i++) begin
                inc_r[i] <= inc_r[i] + incinc_r[i];
                if (step_next[i]) acc[i] <= sum[i] - ROLLBACK;
                else              acc[i] <= sum[i];
              end
              if (ticks_left == DUR_W'(1)) begin
                move_done <= 1'b1;
                state     <= ((count != '0) || push) ? LOAD : IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DDA_POSITION_EN
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      position_o <= '0;
    end else begin
      for (int unsigned i = 0; i < AXES; i++) begin
        if (step_next[i]) begin
          if (dir_o[i]) position_o[i*32 +: 32] <= position_o[i*32 +: 32] + 32'd1;
          else          position_o[i*32 +: 32] <= position_o[i*32 +: 32] - 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dda_move_engine.sv
// Self-checking bench for dda_move_engine (AXES=2, DEPTH=4, ACC_W=32).
module tb_dda_move_engine;
  localparam int unsigned AXES  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned DUR_W = 16;
  localparam logic signed [31:0] RB = 32'sh7FFF_FFFF;

  logic                  CLK = 1'b0;
  logic                  resetn = 1'b0;
  logic                  halt = 1'b0;
  logic                  mv_valid = 1'b0;
  logic [7:0]            clk_div = '0;
  logic                  mv_ready;
  logic [DUR_W-1:0]      mv_dur = '0;
  logic [AXES-1:0]       mv_dir = '0;
  logic [AXES*ACC_W-1:0] mv_inc = '0;
  logic [AXES*ACC_W-1:0] mv_incinc = '0;
  logic [AXES-1:0]       step_o, dir_o;
  logic                  busy, move_done;
  logic [2:0]            fifo_count;
`ifdef DDA_POSITION_EN
  logic [AXES*32-1:0]    position_o;
`endif

  dda_move_engine #(.AXES(AXES), .DEPTH(DEPTH), .ACC_W(ACC_W), .DUR_W(DUR_W)) dut (
    .CLK(CLK), .resetn(resetn), .clk_div(clk_div), .halt(halt),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_dur(mv_dur), .mv_dir(mv_dir),
    .mv_inc(mv_inc), .mv_incinc(mv_incinc), .step_o(step_o), .dir_o(dir_o),
    .busy(busy), .move_done(move_done),
`ifdef DDA_POSITION_EN
    .position_o(position_o),
`endif
    .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  int cyc_n = 0;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  // Output monitor, sampled mid-cycle.
  int step_cnt [AXES];
  int done_cnt = 0;
  int st0_q[$];
  int done_q[$];
  int mv_steps [AXES][256];
  logic [AXES-1:0] mv_dir_seen [256];

  always @(negedge CLK) begin
    for (int a = 0; a < AXES; a++)
      if (step_o[a] === 1'b1) begin
        step_cnt[a]++;
        if (done_cnt < 256) mv_steps[a][done_cnt]++;
      end
    if (step_o[0] === 1'b1) st0_q.push_back(cyc_n);
    if (move_done === 1'b1) begin
      if (done_cnt < 256) mv_dir_seen[done_cnt] = dir_o;
      done_q.push_back(cyc_n);
      done_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; halt = 1'b0; mv_valid = 1'b0;
    cyc(3);
    resetn = 1'b1;
    cyc(1);
  endtask

  // Presents a move and returns the edge index at which it was accepted.
  task automatic send_move(input logic [15:0] dur, input logic [1:0] dir,
                           input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] ii0, input logic [31:0] ii1,
                           output int acc_edge);
    int w;
    mv_dur = dur; mv_dir = dir; mv_inc = {i1, i0}; mv_incinc = {ii1, ii0};
    mv_valid = 1'b1;
    #0;
    w = 0;
    while (!mv_ready && w < 500) begin
      cyc();
      w++;
    end
    if (!mv_ready) chk("send_timeout", 64'd0, 64'd1);
    acc_edge = cyc_n + 1;
    cyc();
    mv_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      cyc();
      k++;
    end
  endtask

  typedef struct {
    logic [7:0]  div;
    logic [15:0] dur;
    logic [1:0]  dir;
    logic [31:0] i0, i1, ii0, ii1;
    int          e_s0, e_s1, e_first, e_gap;
  } vec_t;

  vec_t tv[5];

  initial begin
    int a0, a1, bd, bq, bs0, bs1, nstep;
    int   nm;
    logic [15:0] rdur [12];
    logic [1:0]  rdir [12];
    logic [31:0] ri [12][2];
    logic [31:0] rii [12][2];
    int          exp_st [12][2];
    logic signed [31:0] macc [2];
    logic signed [31:0] minc, s;

    tv[0] = '{8'd0, 16'd4, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 4, 0, 3, 1};
    tv[1] = '{8'd3, 16'd4, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 4, 0, 6, 4};
    tv[2] = '{8'd1, 16'd3, 2'b10, 32'h40000000, 32'h7FFFFFFF, 32'h0, 32'h0, 2, 3, 4, 2};
    tv[3] = '{8'd0, 16'd4, 2'b01, 32'h0, 32'h0, 32'h40000000, 32'h0, 2, 0, 4, 1};
    tv[4] = '{8'd2, 16'd1, 2'b11, 32'h1, 32'h1, 32'h0, 32'h0, 1, 1, 5, 0};

    // Reset and idle
    do_reset();
    chk("rst_ready", 64'(mv_ready), 64'd1);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dir", 64'(dir_o), 64'd0);
    chk("rst_done", 64'(move_done), 64'd0);
    cyc(100);
    chk("idle_steps", 64'(step_cnt[0] + step_cnt[1]), 64'd0);
`ifdef DDA_POSITION_EN
    chk("rst_position", 64'(position_o), 64'd0);
`endif

    // Randomized moves against a tick-by-tick accumulator model
    do_reset();
    clk_div = 8'($urandom_range(0, 2));
    nm = 12;
    bd = done_cnt;
    macc[0] = '0; macc[1] = '0;
    for (int m = 0; m < nm; m++) begin
      rdur[m] = 16'($urandom_range(0, 6));
      rdir[m] = 2'($urandom_range(0, 3));
      for (int a = 0; a < 2; a++) begin
        ri[m][a]  = $urandom;
        rii[m][a] = $urandom;
        exp_st[m][a] = 0;
        minc = ri[m][a];
        for (int t = 0; t < int'(rdur[m]); t++) begin
          s = macc[a] + minc;
          if (s > 0) begin
            macc[a] = s - RB;
            exp_st[m][a]++;
          end else begin
            macc[a] = s;
          end
          minc = minc + rii[m][a];
        end
      end
    end
    for (int m = 0; m < nm; m++)
      send_move(rdur[m], rdir[m], ri[m][0], ri[m][1], rii[m][0], rii[m][1], a0);
    wait_done(bd + nm, 4000);
    cyc(20);
    chk("rnd_done_count", 64'(done_cnt), 64'(bd + nm));
    for (int m = 0; m < nm; m++) begin
      chk($sformatf("rnd_m%0d_steps0", m), 64'(mv_steps[0][bd + m]), 64'(exp_st[m][0]));
      chk($sformatf("rnd_m%0d_steps1", m), 64'(mv_steps[1][bd + m]), 64'(exp_st[m][1]));
      chk($sformatf("rnd_m%0d_dir", m), 64'(mv_dir_seen[bd + m]), 64'(rdir[m]));
    end

    // Table-driven single moves
    for (int k = 0; k < 5; k++) begin
      do_reset();
      clk_div = tv[k].div;
      bs0 = step_cnt[0]; bs1 = step_cnt[1]; bd = done_cnt; bq = st0_q.size();
      send_move(tv[k].dur, tv[k].dir, tv[k].i0, tv[k].i1, tv[k].ii0, tv[k].ii1, a0);
      wait_done(bd + 1, 400);
      cyc(10);
      chk($sformatf("tv%0d_steps0", k), 64'(step_cnt[0] - bs0), 64'(tv[k].e_s0));
      chk($sformatf("tv%0d_steps1", k), 64'(step_cnt[1] - bs1), 64'(tv[k].e_s1));
      chk($sformatf("tv%0d_done_count", k), 64'(done_cnt - bd), 64'd1);
      chk($sformatf("tv%0d_dir", k), 64'(dir_o), 64'(tv[k].dir));
      chk($sformatf("tv%0d_busy", k), 64'(busy), 64'd0);
      if (done_q.size() > bd)
        chk($sformatf("tv%0d_done_time", k), 64'(done_q[bd] - a0),
            64'(3 + int'(tv[k].div) + (int'(tv[k].dur) - 1) * (int'(tv[k].div) + 1)));
      if (st0_q.size() > bq)
        chk($sformatf("tv%0d_first_step", k), 64'(st0_q[bq] - a0), 64'(tv[k].e_first));
      if (tv[k].e_gap != 0 && st0_q.size() > bq + 1)
        chk($sformatf("tv%0d_step_gap", k), 64'(st0_q[bq + 1] - st0_q[bq]), 64'(tv[k].e_gap));
    end

    // FIFO fill while a long move runs, then a write while full
    do_reset();
    clk_div = 8'd0;
    bs0 = step_cnt[0]; bs1 = step_cnt[1]; bd = done_cnt;
    send_move(16'd20, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a0);
    cyc(2);
    for (int m = 0; m < 4; m++)
      send_move(16'd2, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a1);
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_ready", 64'(mv_ready), 64'd0);
    mv_dur = 16'd9; mv_valid = 1'b1;
    cyc();
    mv_valid = 1'b0;
    chk("full_write_dropped", 64'(fifo_count), 64'd4);
    wait_done(bd + 5, 600);
    cyc(20);
    chk("fill_done_count", 64'(done_cnt - bd), 64'd5);
    chk("fill_steps0", 64'(step_cnt[0] - bs0), 64'd28);
    chk("fill_steps1", 64'(step_cnt[1] - bs1), 64'd0);
    chk("fill_count_end", 64'(fifo_count), 64'd0);
    for (int m = 1; m < 5; m++)
      if (done_q.size() > bd + m)
        chk($sformatf("fill_done_gap%0d", m), 64'(done_q[bd + m] - done_q[bd + m - 1]), 64'd3);

    // Zero-duration move followed by a two-tick move
    do_reset();
    clk_div = 8'd0;
    bs0 = step_cnt[0]; bd = done_cnt; bq = st0_q.size();
    send_move(16'd0, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a0);
    send_move(16'd2, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a1);
    wait_done(bd + 2, 200);
    cyc(10);
    chk("dur0_done_count", 64'(done_cnt - bd), 64'd2);
    chk("dur0_steps", 64'(step_cnt[0] - bs0), 64'd2);
    if (done_q.size() > bd + 1) begin
      chk("dur0_done0_time", 64'(done_q[bd] - a0), 64'd2);
      chk("dur0_done1_time", 64'(done_q[bd + 1] - a0), 64'd5);
    end
    if (st0_q.size() > bq) chk("dur0_first_step", 64'(st0_q[bq] - a0), 64'd4);

    // Halt mid-move with two moves queued
    do_reset();
    clk_div = 8'd1;
    bs0 = step_cnt[0]; bd = done_cnt;
    send_move(16'd10, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a0);
    send_move(16'd3, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a1);
    send_move(16'd3, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a1);
    chk("halt_queued", 64'(fifo_count), 64'd2);
    nstep = 0;
    for (int k = 0; k < 200 && nstep < 2; k++) begin
      cyc();
      if (step_o[0]) nstep++;
    end
    halt = 1'b1; mv_valid = 1'b1; mv_dur = 16'd5;
    #1;
    chk("halt_ready", 64'(mv_ready), 64'd0);
    cyc();
    chk("halt_count", 64'(fifo_count), 64'd0);
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_step", 64'(step_o), 64'd0);
    halt = 1'b0; mv_valid = 1'b0;
    cyc(40);
    chk("halt_steps_total", 64'(step_cnt[0] - bs0), 64'd2);
    chk("halt_no_done", 64'(done_cnt - bd), 64'd0);
    chk("halt_dir_hold", 64'(dir_o), 64'd1);
    chk("halt_count_after", 64'(fifo_count), 64'd0);
`ifdef DDA_POSITION_EN
    chk("halt_position0", 64'(position_o[31:0]), 64'd2);
    chk("halt_position1", 64'(position_o[63:32]), 64'd0);
`endif

    // Reset asserted mid-move
    do_reset();
    clk_div = 8'd0;
    bd = done_cnt;
    send_move(16'd30, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a0);
    send_move(16'd3, 2'b01, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, a1);
    cyc(6);
    resetn = 1'b0;
    cyc();
    bs0 = step_cnt[0];
    chk("midrst_step", 64'(step_o), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    cyc(2);
    resetn = 1'b1;
    cyc(30);
    chk("midrst_no_steps", 64'(step_cnt[0] - bs0), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - bd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
